// File: rtl/thermo_hyst_ctrl.sv
// -----------------------------------------------------------------------------
// thermo_hyst_ctrl
//
// Hysteresis thermostat controller. A registered four-state FSM (IDLE, COOL,
// HEAT, FAULT) drives one heater enable and one cooler enable from an unsigned
// temperature sample. Four programmable thresholds set the on and off points.
// A dwell counter holds an actuator on for at least DWELL cycles.
//
// Optional feature: the macro THERMO_FAULT_DETECT_EN enables sensor-fault
// detection. When T is all-zeros or all-ones for two consecutive cycles, the
// FSM moves to a sticky FAULT state. Only reset leaves FAULT. If the macro is
// not defined, FAULT cannot be reached and no detection logic is built.
//
// Parameters:
//   TW     temperature / threshold width (unsigned)
//   DWELL  minimum number of cycles an actuator stays on (1..255)
//
// Ports:
//   clk          clock, rising edge
//   rstN         asynchronous active-low reset
//   T            sampled temperature
//   cfg_load     one-cycle strobe that captures the four threshold inputs
//   heat_on_th   candidate heat-on threshold  (heat when T below it)
//   heat_off_th  candidate heat-off threshold (stop heating when T above it)
//   cool_off_th  candidate cool-off threshold (stop cooling when T below it)
//   cool_on_th   candidate cool-on threshold  (cool when T above it)
//   cfg_err      one-cycle pulse after a cfg_load that was rejected
//   Heater       heater enable (registered)
//   Cooler       cooler enable (registered)
//   state        00 IDLE, 01 COOL, 10 HEAT, 11 FAULT
// -----------------------------------------------------------------------------
module thermo_hyst_ctrl #(
    parameter int TW    = 8,
    parameter int DWELL = 4
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic [TW-1:0] T,
    input  logic          cfg_load,
    input  logic [TW-1:0] heat_on_th,
    input  logic [TW-1:0] heat_off_th,
    input  logic [TW-1:0] cool_off_th,
    input  logic [TW-1:0] cool_on_th,
    output logic          cfg_err,
    output logic          Heater,
    output logic          Cooler,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COOL  = 2'b01,
        ST_HEAT  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    // Reset thresholds. Each value is truncated when TW is narrow.
    localparam logic [TW-1:0] RST_HEAT_ON  = TW'(32'd15);
    localparam logic [TW-1:0] RST_HEAT_OFF = TW'(32'd30);
    localparam logic [TW-1:0] RST_COOL_OFF = TW'(32'd25);
    localparam logic [TW-1:0] RST_COOL_ON  = TW'(32'd35);
    localparam logic [7:0]    DWELL_LOAD   = 8'(DWELL - 1);

    // A threshold set is accepted only when the heat and cool bands are
    // ordered and do not overlap.
    function automatic logic cfg_valid(
        input logic [TW-1:0] h_on,
        input logic [TW-1:0] h_off,
        input logic [TW-1:0] c_off,
        input logic [TW-1:0] c_on
    );
        return (h_on < h_off) && (h_off <= c_off) && (c_off < c_on);
    endfunction

    state_t        state_r;
    state_t        fsm_next_s;
    state_t        state_s;
    logic [7:0]    dwell_r;
    logic          dwell_done_s;
    logic [TW-1:0] heat_on_r;
    logic [TW-1:0] heat_off_r;
    logic [TW-1:0] cool_off_r;
    logic [TW-1:0] cool_on_r;
    logic          cfg_ok_s;
    logic          cfg_err_r;
    logic          heater_r;
    logic          cooler_r;

    assign dwell_done_s = (dwell_r == 8'd0);
    assign cfg_ok_s     = cfg_valid(heat_on_th, heat_off_th, cool_off_th, cool_on_th);

    // Hysteresis transitions. Heating is checked first in IDLE.
    // HEAT and COOL can only return to IDLE, so a heat/cool swap always
    // passes through at least one IDLE cycle.
    always_comb begin
        fsm_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (T < heat_on_r) begin
                    fsm_next_s = ST_HEAT;
                end else if (T > cool_on_r) begin
                    fsm_next_s = ST_COOL;
                end else begin
                    fsm_next_s = ST_IDLE;
                end
            end
            ST_HEAT: begin
                if ((T > heat_off_r) && dwell_done_s) begin
                    fsm_next_s = ST_IDLE;
                end else begin
                    fsm_next_s = ST_HEAT;
                end
            end
            ST_COOL: begin
                if ((T < cool_off_r) && dwell_done_s) begin
                    fsm_next_s = ST_IDLE;
                end else begin
                    fsm_next_s = ST_COOL;
                end
            end
`ifdef THERMO_FAULT_DETECT_EN
            ST_FAULT: fsm_next_s = ST_FAULT;
`else
            ST_FAULT: fsm_next_s = ST_IDLE;
`endif
            default:  fsm_next_s = ST_IDLE;
        endcase
    end

`ifdef THERMO_FAULT_DETECT_EN
    logic sensor_ext_s;
    logic ext_prev_r;

    assign sensor_ext_s = (T == {TW{1'b0}}) || (T == {TW{1'b1}});
    // A sensor stuck at either rail for a second cycle overrides dwell.
    assign state_s      = (sensor_ext_s && ext_prev_r) ? ST_FAULT : fsm_next_s;

    // Remember whether the previous sample was at a rail.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ext_prev_r <= 1'b0;
        end else begin
            ext_prev_r <= sensor_ext_s;
        end
    end
`else
    assign state_s = fsm_next_s;
`endif

    // State register and registered actuator enables.
    // Reset drops the actuators at once, without waiting for the dwell time.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r  <= ST_IDLE;
            heater_r <= 1'b0;
            cooler_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            heater_r <= (state_s == ST_HEAT);
            cooler_r <= (state_s == ST_COOL);
        end
    end

    // Dwell counter. It loads on entry to HEAT or COOL, then counts down and
    // holds at zero.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            dwell_r <= 8'd0;
        end else if ((state_s != state_r) &&
                     ((state_s == ST_HEAT) || (state_s == ST_COOL))) begin
            dwell_r <= DWELL_LOAD;
        end else if (dwell_r != 8'd0) begin
            dwell_r <= dwell_r - 8'd1;
        end else begin
            dwell_r <= 8'd0;
        end
    end

    // Threshold bank. All four values update together on a valid load.
    // A rejected load leaves the bank unchanged and raises cfg_err for one cycle.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            heat_on_r  <= RST_HEAT_ON;
            heat_off_r <= RST_HEAT_OFF;
            cool_off_r <= RST_COOL_OFF;
            cool_on_r  <= RST_COOL_ON;
            cfg_err_r  <= 1'b0;
        end else begin
            cfg_err_r <= cfg_load && !cfg_ok_s;
            if (cfg_load && cfg_ok_s) begin
                heat_on_r  <= heat_on_th;
                heat_off_r <= heat_off_th;
                cool_off_r <= cool_off_th;
                cool_on_r  <= cool_on_th;
            end else begin
                heat_on_r  <= heat_on_r;
                heat_off_r <= heat_off_r;
                cool_off_r <= cool_off_r;
                cool_on_r  <= cool_on_r;
            end
        end
    end

    assign state   = state_r;
    assign Heater  = heater_r;
    assign Cooler  = cooler_r;
    assign cfg_err = cfg_err_r;

endmodule

// File: tb/tb_thermo_hyst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_thermo_hyst_ctrl
//
// Self-checking bench for thermo_hyst_ctrl. The driver applies one input set
// each cycle. A behavioural model predicts the outputs after the next rising
// edge and pushes the prediction into a queue. A monitor on the falling edge
// pops each prediction and compares it with the DUT outputs. The model tracks
// the mode and the number of cycles spent in it. Directed scenarios come first,
// followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_thermo_hyst_ctrl;

    localparam int TW    = 8;
    localparam int DWELL = 4;
    localparam int TMAX  = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rstN;
    logic [TW-1:0] t_in;
    logic          cfg_load;
    logic [TW-1:0] heat_on_th;
    logic [TW-1:0] heat_off_th;
    logic [TW-1:0] cool_off_th;
    logic [TW-1:0] cool_on_th;
    logic          cfg_err;
    logic          heater;
    logic          cooler;
    logic [1:0]    state;

    always #5 clk = ~clk;

    thermo_hyst_ctrl #(.TW(TW), .DWELL(DWELL)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .T           (t_in),
        .cfg_load    (cfg_load),
        .heat_on_th  (heat_on_th),
        .heat_off_th (heat_off_th),
        .cool_off_th (cool_off_th),
        .cool_on_th  (cool_on_th),
        .cfg_err     (cfg_err),
        .Heater      (heater),
        .Cooler      (cooler),
        .state       (state)
    );

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       heat;
        logic       cool;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: mode 0 idle, 1 cool, 2 heat, 3 fault.
    int m_mode;
    int m_elapsed;
    int m_hon, m_hoff, m_coff, m_con;
    bit m_err;
    bit m_prev_ext;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_mode     = 0;
        m_elapsed  = 0;
        m_hon      = 15;
        m_hoff     = 30;
        m_coff     = 25;
        m_con      = 35;
        m_err      = 1'b0;
        m_prev_ext = 1'b0;
    endtask

    task automatic model_step(input int t, input bit ld, input int a, input int b,
                              input int c, input int d);
        int nm;
        bit dwell_met;
        bit ext;
        nm        = m_mode;
        dwell_met = (m_elapsed >= DWELL - 1);
        ext       = (t == 0) || (t == TMAX);
        case (m_mode)
            0: begin
                if (t < m_hon) nm = 2;
                else if (t > m_con) nm = 1;
            end
            2: if (t > m_hoff && dwell_met) nm = 0;
            1: if (t < m_coff && dwell_met) nm = 0;
            default: nm = m_mode;
        endcase
`ifdef THERMO_FAULT_DETECT_EN
        if (m_mode == 3 || (ext && m_prev_ext)) nm = 3;
`endif
        m_prev_ext = ext;
        if (nm != m_mode) m_elapsed = 0;
        else m_elapsed++;
        m_mode = nm;
        m_err  = ld && !((a < b) && (b <= c) && (c < d));
        if (ld && !m_err) begin
            m_hon  = a;
            m_hoff = b;
            m_coff = c;
            m_con  = d;
        end
    endtask

    function automatic exp_t model_out(input string tag);
        exp_t e;
        e.tag  = tag;
        e.st   = 2'(m_mode);
        e.heat = (m_mode == 2);
        e.cool = (m_mode == 1);
        e.err  = m_err;
        return e;
    endfunction

    // Drive one cycle of inputs and queue the predicted post-edge outputs.
    task automatic cycle(input string tag, input int t, input bit ld = 1'b0,
                         input int a = 0, input int b = 0, input int c = 0, input int d = 0);
        @(negedge clk);
        #1;
        t_in        = TW'(t);
        cfg_load    = ld;
        heat_on_th  = TW'(a);
        heat_off_th = TW'(b);
        cool_off_th = TW'(c);
        cool_on_th  = TW'(d);
        model_step(t, ld, a, b, c, d);
        exp_q.push_back(model_out(tag));
    endtask

    // Assert reset between clock edges, check that the outputs drop at once,
    // then release. The first edge after release is predicted and queued.
    task automatic mid_reset(input string tag);
        @(negedge clk);
        #2;
        t_in     = TW'(20);
        cfg_load = 1'b0;
        rstN     = 1'b0;
        #1;
        check({tag, "/heater"}, int'(heater), 0);
        check({tag, "/cooler"}, int'(cooler), 0);
        check({tag, "/state"},  int'(state),  0);
        check({tag, "/cfg_err"}, int'(cfg_err), 0);
        #1;
        rstN = 1'b1;
        model_reset();
        model_step(20, 1'b0, 0, 0, 0, 0);
        exp_q.push_back(model_out({tag, "_release"}));
    endtask

    // Monitor: compare each queued prediction on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check({mon_e.tag, "/state"},   int'(state),   int'(mon_e.st));
            check({mon_e.tag, "/heater"},  int'(heater),  int'(mon_e.heat));
            check({mon_e.tag, "/cooler"},  int'(cooler),  int'(mon_e.cool));
            check({mon_e.tag, "/cfg_err"}, int'(cfg_err), int'(mon_e.err));
            check({mon_e.tag, "/exclusive"}, int'(heater && cooler), 0);
        end
    end

    // Watchdog: stop a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN        = 1'b0;
        t_in        = TW'(20);
        cfg_load    = 1'b0;
        heat_on_th  = '0;
        heat_off_th = '0;
        cool_off_th = '0;
        cool_on_th  = '0;
        model_reset();

        repeat (2) @(negedge clk);
        check("reset/state",   int'(state),   0);
        check("reset/heater",  int'(heater),  0);
        check("reset/cooler",  int'(cooler),  0);
        check("reset/cfg_err", int'(cfg_err), 0);
        #3;
        rstN = 1'b1;
        model_step(20, 1'b0, 0, 0, 0, 0);
        exp_q.push_back(model_out("release"));

        // Inside the hysteresis band: stays idle.
        repeat (6) cycle("idle20", 20);

        // Heat for exactly DWELL cycles, then idle, then cool.
        cycle("heat_entry", 10);
        repeat (6) cycle("heat_dwell", 40);
        repeat (6) cycle("cool_exit", 20);

        // Cool entry; equal to cool_off holds; below cool_off exits.
        cycle("cool_entry", 36);
        repeat (4) cycle("cool_eq", 25);
        repeat (2) cycle("cool_below", 24);
        repeat (2) cycle("settle", 20);

        // Equality at heat_on / cool_on causes no transition.
        repeat (2) cycle("eq_heat_on", 15);
        repeat (2) cycle("eq_cool_on", 35);

        // Rejected config, then an accepted one that moves heat_on down.
        cycle("cfg_bad", 20, 1'b1, 20, 18, 22, 40);
        cycle("cfg_bad_after", 20);
        cycle("cfg_good", 20, 1'b1, 10, 20, 22, 40);
        repeat (3) cycle("new_th", 14);
        repeat (2) cycle("new_th_cool", 41);

        // Reset in the middle of HEAT drops the heater immediately.
        mid_reset("pre_heat_reset");
        cycle("heat_again", 10);
        cycle("heat_hold", 10);
        mid_reset("heat_reset");
        repeat (2) cycle("post_reset", 20);

`ifdef THERMO_FAULT_DETECT_EN
        cycle("fault_cool", 36);
        repeat (2) cycle("fault_rail", TMAX);
        repeat (3) cycle("fault_sticky", 20);
        mid_reset("fault_reset");
        repeat (2) cycle("fault_cleared", 20);
`endif

        // Randomized traffic around the thresholds, with occasional loads.
        for (int i = 0; i < 3000; i++) begin
            int t, a, b, c, d;
            bit ld;
            ld = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom_range(0, 60);
                b = a + 1 + $urandom_range(0, 30);
                c = b + $urandom_range(0, 20);
                d = c + 1 + $urandom_range(0, 40);
            end else begin
                a = $urandom_range(0, TMAX);
                b = $urandom_range(0, TMAX);
                c = $urandom_range(0, TMAX);
                d = $urandom_range(0, TMAX);
            end
            if ($urandom_range(0, 40) == 0) t = ($urandom_range(0, 1) == 1) ? TMAX : 0;
            else if ($urandom_range(0, 7) == 0) t = $urandom_range(0, TMAX);
            else t = $urandom_range(0, 200);
            cycle("rand", t, ld, a, b, c, d);
        end

        cycle("tail", 20);
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
